// File: rtl/obi_axil_pkg.sv
// Shared types and constants for the OBI -> AXI4-Lite data bridge.
package obi_axil_pkg;

    localparam int OBI_ADDR_W             = 32;
    localparam int OBI_DATA_W             = 32;
    localparam int OBI_BE_W               = OBI_DATA_W / 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    // Bridge sequencing: one OBI access in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,  // AW and/or W still pending
        ST_WRESP = 3'd2,  // waiting for B
        ST_READ  = 3'd3,  // AR pending
        ST_RDATA = 3'd4   // waiting for R
    } state_e;

endpackage

// File: rtl/obi_axil_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT_CYCLES-th such cycle. Only instantiated when OBI_AXIL_TIMEOUT_EN is defined.
module obi_axil_watchdog
    import obi_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Cycle counter: restarts at grant, advances while the bridge is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Expiry is combinational so the abort lands on the last counted cycle.
    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/obi_axil_data_bridge.sv
// Single-outstanding bridge from the core's OBI data port to an AXI4-Lite slave.
// Optional watchdog abort is compiled in with `define OBI_AXIL_TIMEOUT_EN.
// dbg_state exposes the FSM state for observation.
module obi_axil_data_bridge
    import obi_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    // OBI slave side (from the LSU)
    input  logic        obi_req,
    output logic        obi_gnt,
    input  logic [31:0] obi_addr,
    input  logic        obi_we,
    input  logic [3:0]  obi_be,
    input  logic [31:0] obi_wdata,
    output logic        obi_rvalid,
    output logic [31:0] obi_rdata,
    output logic        obi_err,
    // AXI4-Lite master side (to the RAM data port)
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready,
    // Debug
    output logic [2:0]  dbg_state
);

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; a raised valid and its payload stay stable
    // until that edge, and valid never waits on ready.

    state_e                state_q, state_d;
    logic [OBI_ADDR_W-1:0] addr_q;
    logic [OBI_BE_W-1:0]   be_q;
    logic [OBI_DATA_W-1:0] wdata_q;
    logic                  aw_done_q, w_done_q;
    logic                  grant, aw_hs, w_hs, wr_both;
    logic                  wr_done, rd_done, abort, abort_rsp;

    assign grant     = (state_q == ST_IDLE) && obi_req;
    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;
    assign wr_both   = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign wr_done   = (state_q == ST_WRESP) && m_bvalid;
    assign rd_done   = (state_q == ST_RDATA) && m_rvalid;
    // A completing response wins over a simultaneous expiry.
    assign abort_rsp = abort && !wr_done && !rd_done;

`ifdef OBI_AXIL_TIMEOUT_EN
    obi_axil_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (grant),
        .enable  (state_q != ST_IDLE),
        .expired (abort)
    );
`else
    // No watchdog: never abort. TIMEOUT_CYCLES is folded into a constant-false
    // term so the parameter stays referenced in this build.
    assign abort = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (obi_req) state_d = obi_we ? ST_WRITE : ST_READ;
            ST_WRITE: begin
                if (abort)        state_d = ST_IDLE;
                else if (wr_both) state_d = ST_WRESP;
            end
            ST_WRESP: if (m_bvalid || abort) state_d = ST_IDLE;
            ST_READ: begin
                if (abort)          state_d = ST_IDLE;
                else if (m_arready) state_d = ST_RDATA;
            end
            ST_RDATA: if (m_rvalid || abort) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: valids from state and done flags; B/R also accepted in IDLE to drain strays.
    always_comb begin
        obi_gnt   = grant;
        m_awvalid = (state_q == ST_WRITE) && !aw_done_q;
        m_wvalid  = (state_q == ST_WRITE) && !w_done_q;
        m_arvalid = (state_q == ST_READ);
        m_bready  = (state_q == ST_IDLE) || (state_q == ST_WRESP);
        m_rready  = (state_q == ST_IDLE) || (state_q == ST_RDATA);
    end

    // Request capture at grant; held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            addr_q  <= obi_addr;
            be_q    <= obi_be;
            wdata_q <= obi_wdata;
        end
    end

    // Per-channel completion flags so AW and W can finish in either order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (grant) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end
    end

    // Registered OBI response: one-cycle pulse, data only for completed reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obi_rvalid <= 1'b0;
            obi_rdata  <= '0;
            obi_err    <= 1'b0;
        end else begin
            obi_rvalid <= wr_done || rd_done || abort_rsp;
            obi_rdata  <= rd_done ? m_rdata : '0;
            obi_err    <= abort_rsp;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = be_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_obi_axil_data_bridge.sv
// Bench for obi_axil_data_bridge: behavioural AXI4-Lite RAM slave, a word-level
// memory model that predicts each OBI response, and directed timing checks.
module tb_obi_axil_data_bridge;

`ifdef OBI_AXIL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        obi_req = 1'b0, obi_gnt, obi_we = 1'b0;
  logic [31:0] obi_addr = '0, obi_wdata = '0, obi_rdata;
  logic [3:0]  obi_be = '0;
  logic        obi_rvalid, obi_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]  dbg_state;

  obi_axil_data_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
    .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_rvalid(obi_rvalid),
    .obi_rdata(obi_rdata), .obi_err(obi_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- AXI4-Lite RAM slave ----------------
  logic [31:0] ram [logic [29:0]];
  int          aw_hold = 0;        // cycles of AW-valid to refuse before accepting
  logic        ar_block = 1'b0;    // never accept AR while set
  logic        sl_rst, aw_f, aw_v, w_f, ar_f, b_f, r_f, got_aw, got_w;
  logic [31:0] sl_awa, sl_ara, sl_wd, cur_awa, cur_ara, cur_wd;
  logic [3:0]  sl_ws, cur_ws;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a[31:2]) ? ram[a[31:2]] : 32'h0;
  endfunction

  initial begin
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    got_aw = 1'b0; got_w = 1'b0;
    forever begin
      @(negedge clk);
      sl_rst = !rst_n;
      aw_v = m_awvalid; aw_f = m_awvalid && m_awready;
      w_f = m_wvalid && m_wready; ar_f = m_arvalid && m_arready;
      b_f = m_bvalid && m_bready; r_f = m_rvalid && m_rready;
      cur_awa = m_awaddr; cur_ara = m_araddr; cur_wd = m_wdata; cur_ws = m_wstrb;
      @(posedge clk); #1;
      if (sl_rst) begin
        m_bvalid = 1'b0; m_rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
      end else begin
        if (b_f) m_bvalid = 1'b0;
        if (r_f) m_rvalid = 1'b0;
        if (aw_f) begin got_aw = 1'b1; sl_awa = cur_awa; end
        if (w_f) begin got_w = 1'b1; sl_wd = cur_wd; sl_ws = cur_ws; end
        if (got_aw && got_w) begin
          ram[sl_awa[31:2]] = merge(ram_rd(sl_awa), sl_wd, sl_ws);
          m_bvalid = 1'b1; got_aw = 1'b0; got_w = 1'b0;
        end
        if (ar_f) begin m_rvalid = 1'b1; m_rdata = ram_rd(cur_ara); end
        if (aw_v && !aw_f && aw_hold > 0) aw_hold--;
      end
      m_awready = (aw_hold == 0);
      m_arready = !ar_block;
    end
  end

  // ---------------- model + scoreboard / compare process ----------------
  logic [31:0] model_mem [logic [29:0]];
  logic [32:0] exp_q[$];             // {err, rdata}
  logic [32:0] mon_e;
  logic        next_abort = 1'b0;
  int          rsp_cnt = 0, last_rsp_cyc = 0, aw_hs_cyc = 0, w_hs_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a[31:2]) ? model_mem[a[31:2]] : 32'h0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (m_wvalid && m_wready) w_hs_cnt++;
      if (m_awvalid && m_awready) aw_hs_cyc = cyc;
      if (obi_rvalid) begin
        rsp_cnt++; last_rsp_cyc = cyc; last_rdata = obi_rdata; last_err = obi_err;
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 64'(obi_rvalid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", 64'(obi_rdata), 64'(mon_e[31:0]));
          check("rsp_err", 64'(obi_err), 64'(mon_e[32]));
        end
      end
      if (obi_gnt) begin
        check("gnt_needs_req", 64'(obi_req), 64'd1);
        if (next_abort) exp_q.push_back({1'b1, 32'h0});
        else if (obi_we) begin
          model_mem[obi_addr[31:2]] = merge(model_rd(obi_addr), obi_wdata, obi_be);
          exp_q.push_back({1'b0, 32'h0});
        end else exp_q.push_back({1'b0, model_rd(obi_addr)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output int g);
    int n;
    @(posedge clk); #1;
    obi_req = 1'b1; obi_we = we; obi_addr = addr; obi_be = be; obi_wdata = wdata;
    n = 0; g = -1;
    while (g < 0) begin
      @(negedge clk);
      if (obi_gnt) g = cyc;
      else if (++n > 50) begin
        check("gnt_timeout", 64'd0, 64'd1);
        g = cyc;
      end
    end
    @(posedge clk); #1;
    obi_req = 1'b0;
  endtask

  task automatic wait_rsp(input int target, output int rc);
    int n;
    n = 0; rc = -1;
    while (rc < 0) begin
      @(negedge clk); #1;
      if (rsp_cnt >= target) rc = last_rsp_cyc;
      else if (++n > 100) begin
        check("rsp_timeout", 64'd0, 64'd1);
        rc = cyc;
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  int g, rc, n0, w0;
  int gc[4];
  logic rv_at[4];
  logic [31:0] rd_addrs[4];
  int arv_cnt;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_rvalid", 64'(obi_rvalid), 64'd0);
    check("rst_rdata_err", {31'd0, obi_err, obi_rdata}, 64'd0);
    check("rst_valids", {m_awvalid, m_wvalid, m_arvalid}, 64'd0);
    check("rst_readies", {m_bready, m_rready}, 64'd3);
    check("rst_addr", {m_awaddr, m_araddr}, 64'd0);
    check("rst_wdata_strb", {m_wstrb, m_wdata}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // zero-wait write 0x100 <- DEADBEEF
    n0 = rsp_cnt;
    do_req(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, g);
    @(negedge clk);
    check("wr_c1_awvalid_wvalid", {m_awvalid, m_wvalid}, 64'd3);
    check("wr_c1_awaddr", 64'(m_awaddr), 64'h100);
    check("wr_c1_wstrb", 64'(m_wstrb), 64'hF);
    check("wr_c1_wdata", 64'(m_wdata), 64'hDEADBEEF);
    wait_rsp(n0 + 1, rc);
    check("wr_rsp_latency", 64'(rc - g), 64'd3);
    check("wr_rsp_err_rdata", {31'd0, last_err, last_rdata}, 64'd0);

    // read it back from the RAM
    n0 = rsp_cnt;
    do_req(1'b0, 32'h100, 4'hF, 32'h0, g);
    wait_rsp(n0 + 1, rc);
    check("rd_rsp_latency", 64'(rc - g), 64'd3);
    check("rd_rdata_lit", 64'(last_rdata), 64'hDEADBEEF);

    // byte-lane merge
    n0 = rsp_cnt;
    do_req(1'b1, 32'h104, 4'hF, 32'h11223344, g);
    do_req(1'b1, 32'h104, 4'h2, 32'h0000AB00, g);
    do_req(1'b0, 32'h104, 4'hF, 32'h0, g);
    wait_rsp(n0 + 3, rc);
    check("byte_merge_lit", 64'(last_rdata), 64'h1122AB44);

    // AW refused for 3 cycles while W completes at c1
    aw_hold = 3;
    n0 = rsp_cnt; w0 = w_hs_cnt;
    do_req(1'b1, 32'h108, 4'hF, 32'hCAFEF00D, g);
    @(negedge clk);
    check("stall_c1_valids", {m_awvalid, m_wvalid}, 64'd3);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      check("stall_wvalid_low", 64'(m_wvalid), 64'd0);
      check("stall_awvalid_high", 64'(m_awvalid), 64'd1);
      check("stall_awaddr_stable", 64'(m_awaddr), 64'h108);
    end
    wait_rsp(n0 + 1, rc);
    check("stall_w_once", 64'(w_hs_cnt - w0), 64'd1);
    check("stall_aw_hs_cycle", 64'(aw_hs_cyc - g), 64'd4);
    check("stall_rsp_after_aw", 64'(rc - aw_hs_cyc), 64'd2);

    // four back-to-back reads with obi_req held high
    rd_addrs[0] = 32'h100; rd_addrs[1] = 32'h104; rd_addrs[2] = 32'h108; rd_addrs[3] = 32'h10C;
    n0 = rsp_cnt;
    @(posedge clk); #1;
    obi_req = 1'b1; obi_we = 1'b0; obi_be = 4'hF; obi_addr = rd_addrs[0];
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0; gc[k] = -1;
      while (gc[k] < 0) begin
        @(negedge clk);
        if (obi_gnt) begin gc[k] = cyc; rv_at[k] = obi_rvalid; end
        else if (++n > 20) begin check("b2b_gnt_timeout", 64'd0, 64'd1); gc[k] = cyc; rv_at[k] = 1'b0; end
      end
      @(posedge clk); #1;
      if (k < 3) obi_addr = rd_addrs[k+1];
      else obi_req = 1'b0;
    end
    for (int k = 1; k < 4; k++) begin
      check("b2b_gnt_spacing", 64'(gc[k] - gc[0]), 64'(3 * k));
      check("b2b_rvalid_with_gnt", 64'(rv_at[k]), 64'd1);
    end
    wait_rsp(n0 + 4, rc);
    check("b2b_last_rsp", 64'(rc - gc[3]), 64'd3);

    // reset in the middle of a stalled read: valids drop at once, no response
    ar_block = 1'b1;
    do_req(1'b0, 32'h100, 4'hF, 32'h0, g);
    @(negedge clk);
    check("midrst_arvalid_before", 64'(m_arvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("midrst_arvalid_async", 64'(m_arvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; ar_block = 1'b0;
    n0 = rsp_cnt;
    repeat (6) @(negedge clk);
    #1 check("midrst_no_rsp", 64'(rsp_cnt - n0), 64'd0);
    n0 = rsp_cnt;
    do_req(1'b0, 32'h104, 4'hF, 32'h0, g);
    wait_rsp(n0 + 1, rc);
    check("midrst_next_read", 64'(last_rdata), 64'h1122AB44);

`ifdef OBI_AXIL_TIMEOUT_EN
    // watchdog abort with an AR that is never accepted
    ar_block = 1'b1; next_abort = 1'b1;
    n0 = rsp_cnt;
    do_req(1'b0, 32'h100, 4'hF, 32'h0, g);
    arv_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (m_arvalid) arv_cnt++;
    end
    check("to_arvalid_c1_c16", 64'(arv_cnt), 64'd16);
    @(negedge clk);
    check("to_c17_arvalid_low", 64'(m_arvalid), 64'd0);
    check("to_c17_rvalid_err", {obi_rvalid, obi_err}, 64'd3);
    check("to_c17_rdata", 64'(obi_rdata), 64'd0);
    wait_rsp(n0 + 1, rc);
    next_abort = 1'b0; ar_block = 1'b0;
    n0 = rsp_cnt;
    do_req(1'b0, 32'h100, 4'hF, 32'h0, g);
    wait_rsp(n0 + 1, rc);
    check("to_next_read_err", 64'(last_err), 64'd0);
    check("to_next_read_data", 64'(last_rdata), 64'hDEADBEEF);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // hard stop if something wedges outside the bounded waits
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
